i2c_calc_master: RTL and testbench

I2C_CALC_MASTER -- requirements
Module: i2c_calc_master

---
 rtl/i2c_calc_pkg.sv | 58 +++++
 rtl/i2c_tick_gen.sv | 39 +++
 rtl/i2c_calc_master.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_calc_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_calc_pkg
// Description : Shared definitions for the I2C calculator master and target:
//               FSM state encoding, default target address, write-phase byte
//               indices, and the SCL/SDA pull decoders used by the master.
// Revision    : 1.0  initial release
// ============================================================================
package i2c_calc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_WRITE_BIT = 4'd2,
    ST_WRITE_ACK = 4'd3,
    ST_RSTART    = 4'd4,
    ST_READ_BIT  = 4'd5,
    ST_READ_NACK = 4'd6,
    ST_STOP      = 4'd7,
    ST_DONE      = 4'd8
  } state_e;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h2A;

  // Byte index during the write phase
  localparam logic [1:0] BYTE_ADDR_W = 2'd0;
  localparam logic [1:0] BYTE_OPA    = 2'd1;
  localparam logic [1:0] BYTE_OPB    = 2'd2;
  localparam logic [1:0] BYTE_OPCODE = 2'd3;

  // Quarter in which SDA is sampled (sample lands at start of the last one)
  localparam logic [1:0] Q_SAMPLE = 2'd2;
  localparam logic [1:0] Q_LAST   = 2'd3;

  // SCL is pulled low during the first two quarters of every clocked slot.
  function automatic logic scl_pull(input state_e st, input logic [1:0] q);
    case (st)
      ST_WRITE_BIT, ST_WRITE_ACK, ST_RSTART,
      ST_READ_BIT, ST_READ_NACK, ST_STOP: return (q < 2'd2);
      default:                            return 1'b0;
    endcase
  endfunction

  // SDA drive per slot quarter. START falls in q2, repeated START falls in
  // q3 (after SCL has been released in q2), STOP rises in q3.
  function automatic logic sda_pull(input state_e st, input logic [1:0] q,
                                    input logic bit_val);
    case (st)
      ST_START:     return (q >= 2'd2);
      ST_WRITE_BIT: return ~bit_val;
      ST_RSTART:    return (q == Q_LAST);
      ST_STOP:      return (q != Q_LAST);
      default:      return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tick_gen
// Description : Quarter-SCL-period tick generator. Emits a one-cycle tick
//               every CLK_DIV clocks; held at zero while clear_i is high so
//               the first quarter of a transaction is a full CLK_DIV long.
// Revision    : 1.0  initial release
// Ports       : clk_i   - system clock
//               rst_i   - asynchronous active-high reset
//               clear_i - synchronous counter clear (master idle)
//               tick_o  - one-cycle quarter-period tick
// ============================================================================
module i2c_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [7:0] C_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = !clear_i && (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clear_i || tick_o) cnt_d = 8'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/i2c_calc_master.sv
`default_nettype none
// ============================================================================
// Module      : i2c_calc_master
// Description : I2C master that writes operand A, operand B and an opcode to
//               a calculator target, issues a repeated START, reads back one
//               result byte, NACKs it and issues STOP.
// Revision    : 1.0  initial release
// Ports       : clk_i, rst_i          - clock, async active-high reset
//               start_i               - request pulse (sampled when idle)
//               operand_a_i/_b_i      - operands, captured on accepted start
//               opcode_i              - operation byte, captured on start
//               scl_oe_o / sda_oe_o   - 1 = pull line low, 0 = release
//               sda_i                 - sampled SDA line
//               busy_o                - transaction in progress
//               done_o                - one-cycle end-of-transaction pulse
//               ack_err_o             - a byte was not ACKed (valid w/ done)
//               result_o              - byte read from target (held)
// ============================================================================
module i2c_calc_master
  import i2c_calc_pkg::*;
#(
  parameter int         CLK_DIV     = 25,
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] operand_a_i,
  input  logic [7:0] operand_b_i,
  input  logic [7:0] opcode_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  input  logic       sda_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic [7:0] result_o
);

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;       // quarter within the current slot
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [7:0] sr_q, sr_d;             // shared tx/rx shift register
  logic       rd_q, rd_d;             // address byte in flight is addr+R
  logic       err_q, err_d;           // a NACK was seen
  logic [7:0] opa_q, opa_d, opb_q, opb_d, opc_q, opc_d;
  logic [7:0] result_q, result_d;
  logic       ack_err_q, ack_err_d;
  logic       scl_oe_q, sda_oe_q, busy_q, done_q;
  logic       w_tick, w_clear;

  assign w_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (w_clear),
    .tick_o  (w_tick)
  );

  function automatic logic [7:0] byte_sel(input logic [1:0] idx,
                                          input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] op);
    case (idx)
      BYTE_ADDR_W: return {TARGET_ADDR, 1'b0};
      BYTE_OPA:    return a;
      BYTE_OPB:    return b;
      default:     return op;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    sr_d       = sr_q;
    rd_d       = rd_q;
    err_d      = err_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    opc_d      = opc_q;
    result_d   = result_q;
    ack_err_d  = ack_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          opa_d      = operand_a_i;
          opb_d      = operand_b_i;
          opc_d      = opcode_i;
          byte_idx_d = BYTE_ADDR_W;
          sr_d       = {TARGET_ADDR, 1'b0};
          bit_cnt_d  = 3'd7;
          phase_d    = 2'd0;
          rd_d       = 1'b0;
          err_d      = 1'b0;
          state_d    = ST_START;
        end
      end

      // Start requests in this cycle are deliberately dropped.
      ST_DONE: state_d = ST_IDLE;

      default: begin
        if (w_tick) begin
          phase_d = phase_q + 2'd1;

          if (phase_q == Q_SAMPLE) begin
            if (state_q == ST_WRITE_ACK) err_d = sda_i;
            if (state_q == ST_READ_BIT)  sr_d  = {sr_q[6:0], sda_i};
          end

          if (phase_q == Q_LAST) begin
            case (state_q)
              ST_START: state_d = ST_WRITE_BIT;

              ST_WRITE_BIT: begin
                if (bit_cnt_q == 3'd0) begin
                  state_d = ST_WRITE_ACK;
                end else begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
                  sr_d      = {sr_q[6:0], 1'b0};
                end
              end

              ST_WRITE_ACK: begin
                bit_cnt_d = 3'd7;
                if (err_q) begin
                  state_d = ST_STOP;
                end else if (rd_q) begin
                  state_d = ST_READ_BIT;
                end else if (byte_idx_q == BYTE_OPCODE) begin
                  state_d = ST_RSTART;
                end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  sr_d       = byte_sel(byte_idx_q + 2'd1, opa_q, opb_q, opc_q);
                  state_d    = ST_WRITE_BIT;
                end
              end

              ST_RSTART: begin
                sr_d      = {TARGET_ADDR, 1'b1};
                rd_d      = 1'b1;
                bit_cnt_d = 3'd7;
                state_d   = ST_WRITE_BIT;
              end

              ST_READ_BIT: begin
                if (bit_cnt_q == 3'd0) state_d = ST_READ_NACK;
                else                   bit_cnt_d = bit_cnt_q - 3'd1;
              end

              ST_READ_NACK: state_d = ST_STOP;

              ST_STOP: begin
                state_d   = ST_DONE;
                ack_err_d = err_q;
                if (!err_q) result_d = sr_q;
              end

              default: state_d = ST_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      phase_q    <= 2'd0;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      sr_q       <= 8'h00;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      opa_q      <= 8'h00;
      opb_q      <= 8'h00;
      opc_q      <= 8'h00;
      result_q   <= 8'h00;
      ack_err_q  <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      sr_q       <= sr_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      opc_q      <= opc_d;
      result_q   <= result_d;
      ack_err_q  <= ack_err_d;
      // SCL follows the slot boundary directly; SDA is decoded from the
      // current slot so it moves one clock after SCL has gone low, keeping
      // data changes strictly inside the SCL-low window.
      scl_oe_q   <= scl_pull(state_d, phase_d);
      sda_oe_q   <= sda_pull(state_q, phase_q, sr_q[7]);
      busy_q     <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign scl_oe_o  = scl_oe_q;
  assign sda_oe_o  = sda_oe_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ack_err_o = ack_err_q;
  assign result_o  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_calc_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_calc_master
// Description : Directed bench for i2c_calc_master. Two masters (CLK_DIV 25
//               and 2) share one open-drain bus with a behavioural calculator
//               target that returns 8'h0C and can NACK a chosen byte.
// Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_calc_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [7:0] op_a = 8'h00, op_b = 8'h00, op_c = 8'h00;
  logic scl_oe_a, sda_oe_a, busy_a, done_a, ack_err_a;
  logic scl_oe_b, sda_oe_b, busy_b, done_b, ack_err_b;
  logic [7:0] result_a, result_b;
  logic tgt_pull = 1'b0;

  wire scl_line = ~(scl_oe_a | scl_oe_b);
  wire sda_line = ~(sda_oe_a | sda_oe_b | tgt_pull);

  always #5 clk = ~clk;

  i2c_calc_master #(.CLK_DIV(25), .TARGET_ADDR(7'h2A)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a),
    .operand_a_i(op_a), .operand_b_i(op_b), .opcode_i(op_c),
    .scl_oe_o(scl_oe_a), .sda_oe_o(sda_oe_a), .sda_i(sda_line),
    .busy_o(busy_a), .done_o(done_a), .ack_err_o(ack_err_a), .result_o(result_a)
  );

  i2c_calc_master #(.CLK_DIV(2), .TARGET_ADDR(7'h2A)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .operand_a_i(op_a), .operand_b_i(op_b), .opcode_i(op_c),
    .scl_oe_o(scl_oe_b), .sda_oe_o(sda_oe_b), .sda_i(sda_line),
    .busy_o(busy_b), .done_o(done_b), .ack_err_o(ack_err_b), .result_o(result_b)
  );

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- done pulse counters ----------------
  int nd_a = 0, nd_b = 0;
  always @(negedge clk) begin
    if (done_a === 1'b1) nd_a++;
    if (done_b === 1'b1) nd_b++;
  end

  // ---------------- behavioural target + bus monitor ----------------
  int   clr_req = 0, clr_seen = 0;
  int   nack_at = -1;           // write-byte index to NACK (-1 = none)
  logic scl_p = 1'b1, sda_p = 1'b1, s_scl, s_sda;
  int   bitn;
  logic act, rd_mode, tx_arm, first, t_ack, m_nack;
  logic [7:0] sh, tx;
  logic [7:0] log_b [8];
  int   log_n, n_start, n_stop, hi_fall, hi_rise;
  int   cyc = 0, last_rise, per_min, per_max;

  always @(negedge clk) begin
    cyc++;
    s_scl = scl_line;
    s_sda = sda_line;
    if (rst || clr_req != clr_seen) begin
      clr_seen = clr_req;
      bitn = 0; act = 0; rd_mode = 0; tx_arm = 0; first = 0; m_nack = 0;
      sh = 8'h00; tx = 8'h00; tgt_pull = 1'b0;
      log_n = 0; n_start = 0; n_stop = 0; hi_fall = 0; hi_rise = 0;
      last_rise = -1; per_min = 1000000; per_max = 0;
      for (int i = 0; i < 8; i++) log_b[i] = 8'h00;
    end else if (s_scl && scl_p && sda_p && !s_sda) begin
      n_start++; hi_fall++;
      act = 1; bitn = 0; sh = 8'h00; rd_mode = 0; tx_arm = 0; first = 1;
      tgt_pull = 1'b0;
    end else if (s_scl && scl_p && !sda_p && s_sda) begin
      n_stop++; hi_rise++;
      act = 0; tgt_pull = 1'b0;
    end else if (!scl_p && s_scl) begin
      if (last_rise >= 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      last_rise = cyc;
      if (act) begin
        if (bitn < 8) begin
          if (!rd_mode) sh = {sh[6:0], s_sda};
          bitn++;
        end else if (bitn == 8) begin
          if (rd_mode) m_nack = s_sda;
          bitn = 9;
        end
      end
    end else if (scl_p && !s_scl && act) begin
      if (bitn == 8 && !rd_mode) begin
        if (log_n < 8) log_b[log_n] = sh;
        t_ack = (log_n != nack_at);
        if (first) begin
          t_ack  = t_ack && (sh[7:1] == 7'h2A);
          tx_arm = t_ack && sh[0];
        end
        first    = 0;
        log_n++;
        tgt_pull = t_ack;
      end else if (bitn == 8 && rd_mode) begin
        tgt_pull = 1'b0;
      end else if (bitn == 9) begin
        tgt_pull = 1'b0;
        bitn = 0;
        if (rd_mode) begin
          act = 0;
        end else if (tx_arm) begin
          rd_mode  = 1;
          tx       = 8'h0C;
          tgt_pull = ~tx[7];
        end
      end else if (rd_mode && bitn >= 1 && bitn <= 7) begin
        tgt_pull = ~tx[7 - bitn];
      end
    end
    scl_p = s_scl;
    sda_p = s_sda;
  end

  // ---------------- transaction driver ----------------
  task automatic run_txn(input bit sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input int nack, input bit repulse,
                         output logic [7:0] res, output logic err);
    int  base;
    bit  got;
    clr_req++;
    nack_at = nack;
    base = sel ? nd_b : nd_a;
    @(negedge clk);
    op_a = a; op_b = b; op_c = op;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    op_a = 8'hEE; op_b = 8'hEE; op_c = 8'hEE;
    chk("busy_rise", sel ? busy_b : busy_a, 1);
    got = 0; res = 8'h00; err = 1'b0;
    for (int k = 1; k <= 20000 && !got; k++) begin
      @(negedge clk);
      if (repulse && k == 100) begin
        op_a = 8'hFF;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if ((sel ? done_b : done_a) === 1'b1) begin
        got = 1;
        res = sel ? result_b : result_a;
        err = sel ? ack_err_b : ack_err_a;
        chk("busy_low_at_done", sel ? busy_b : busy_a, 0);
      end
    end
    start_a = 1'b0; start_b = 1'b0;
    chk("done_seen", got, 1);
    repeat (20) @(negedge clk);
    chk("done_count", (sel ? nd_b : nd_a) - base, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] res;
  logic       err;
  bit         reached;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_scl_oe",  scl_oe_a,  0);
    chk("rst_sda_oe",  sda_oe_a,  0);
    chk("rst_busy",    busy_a,    0);
    chk("rst_done",    done_a,    0);
    chk("rst_ack_err", ack_err_a, 0);
    chk("rst_result",  result_a,  8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal transaction, CLK_DIV=25, with an ignored start mid-way
    run_txn(1'b0, 8'h05, 8'h07, 8'h00, -1, 1'b1, res, err);
    chk("t1_result",  res, 8'h0C);
    chk("t1_ack_err", err, 0);
    chk("t1_nbytes",  log_n, 5);
    chk("t1_byte0",   log_b[0], 8'h54);
    chk("t1_byte1",   log_b[1], 8'h05);
    chk("t1_byte2",   log_b[2], 8'h07);
    chk("t1_byte3",   log_b[3], 8'h00);
    chk("t1_byte4",   log_b[4], 8'h55);
    chk("t1_mnack",   m_nack, 1);
    chk("t1_starts",  n_start, 2);
    chk("t1_stops",   n_stop, 1);
    chk("t1_sda_hi_fall", hi_fall, 2);
    chk("t1_sda_hi_rise", hi_rise, 1);
    chk("t1_per_min", per_min, 100);
    chk("t1_per_max", per_max, 100);
    chk("t1_result_held", result_a, 8'h0C);

    // Nominal transaction, CLK_DIV=2
    run_txn(1'b1, 8'hA5, 8'h3C, 8'h81, -1, 1'b0, res, err);
    chk("t2_result",  res, 8'h0C);
    chk("t2_ack_err", err, 0);
    chk("t2_byte1",   log_b[1], 8'hA5);
    chk("t2_byte2",   log_b[2], 8'h3C);
    chk("t2_byte3",   log_b[3], 8'h81);
    chk("t2_sda_hi_fall", hi_fall, 2);
    chk("t2_sda_hi_rise", hi_rise, 1);
    chk("t2_per_min", per_min, 8);
    chk("t2_per_max", per_max, 8);

    // No target present: address NACK
    run_txn(1'b1, 8'h12, 8'h34, 8'h56, 0, 1'b0, res, err);
    chk("t3_ack_err", err, 1);
    chk("t3_result",  res, 8'h0C);
    chk("t3_nbytes",  log_n, 1);
    chk("t3_byte0",   log_b[0], 8'h54);
    chk("t3_stops",   n_stop, 1);
    chk("t3_starts",  n_start, 1);

    // Target NACKs operand_b: opcode never sent
    run_txn(1'b1, 8'h11, 8'h22, 8'h33, 2, 1'b0, res, err);
    chk("t4_ack_err", err, 1);
    chk("t4_result",  res, 8'h0C);
    chk("t4_nbytes",  log_n, 3);
    chk("t4_byte2",   log_b[2], 8'h22);
    chk("t4_starts",  n_start, 1);
    chk("t4_stops",   n_stop, 1);

    // Reset during operand_a bit 3, then a clean transaction
    clr_req++;
    nack_at = -1;
    @(negedge clk);
    op_a = 8'h96; op_b = 8'h69; op_c = 8'h03; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    reached = 0;
    for (int k = 0; k < 5000 && !reached; k++) begin
      @(negedge clk);
      if (log_n == 1 && bitn == 4 && !scl_line) reached = 1;
    end
    chk("t5_reached", reached, 1);
    @(negedge clk);
    chk("t5_pre_sda_oe", sda_oe_a, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_scl_oe", scl_oe_a, 0);
    chk("t5_rst_sda_oe", sda_oe_a, 0);
    chk("t5_rst_busy",   busy_a,   0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_result", result_a, 8'h00);
    repeat (5) @(negedge clk);
    run_txn(1'b0, 8'h96, 8'h69, 8'h03, -1, 1'b0, res, err);
    chk("t5_result",  res, 8'h0C);
    chk("t5_ack_err", err, 0);
    chk("t5_byte1",   log_b[1], 8'h96);
    chk("t5_byte3",   log_b[3], 8'h03);
    chk("t5_nbytes",  log_n, 5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
